// File: rtl/rom_scan_seq.sv
// Scans a combinational ROM from addr_lo to addr_hi and hands each byte to a
// ready/valid consumer while keeping a 16-bit running checksum of accepted bytes.
module rom_scan_seq #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 768
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr_lo,
  input  logic [AW-1:0] addr_hi,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   checksum
);

  localparam int unsigned CW      = 16;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] cur;
  logic [AW-1:0] hi_q;
  logic          req_ok_c;

  // Request is legal when the range is non-empty and ends inside the ROM.
  assign req_ok_c = (addr_lo <= addr_hi) && ({1'b0, addr_hi} < DEPTH_W);

  // The ROM address is the registered cursor, so it never glitches within FETCH.
  assign rom_addr = cur;
  assign busy     = (state == FETCH) || (state == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      hi_q      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (req_ok_c) begin
              hi_q     <= addr_hi;
              cur      <= addr_lo;
              checksum <= '0;
              err      <= 1'b0;
              state    <= FETCH;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FETCH: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            checksum  <= checksum + CW'(out_data);
            out_valid <= 1'b0;
            // Stop on the last address rather than incrementing past it.
            if (cur == hi_q) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              cur   <= cur + AW'(1);
              state <= FETCH;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_seq.sv
// Directed bench for rom_scan_seq: a queue-based model of the expected byte
// stream and checksum is checked every cycle, plus literal per-scan expectations.
module tb_rom_scan_seq;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr_lo;
  logic [AW-1:0] addr_hi;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   checksum;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  exp_q[$];
  logic [15:0] model_sum = 16'h0;
  int          n_acc = 0;
  int          done_cnt = 0;
  bit          chk_en = 1'b0;

  rom_scan_seq #(.AW(AW), .DW(DW), .DEPTH(768)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  // ROM contents: word[a] = a[7:0]
  assign rom_data = rom_addr[7:0];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("checksum_track", 32'(checksum), 32'(model_sum));
      if (out_valid) begin
        chk("busy_when_valid", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) begin
            model_sum = model_sum + 16'(exp_q[0]);
            void'(exp_q.pop_front());
            n_acc++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_during_done", 32'(busy), 32'd0);
      end
    end
  end

  // mode 0: ready always high; 1: ready low until cycle hold, with stray start;
  // 2: random ready.
  task automatic run_scan(input int lo, input int hi, input int mode, input int hold,
                          input logic [15:0] exp_sum, input bit exp_err, input int exp_cycles);
    int cycles;
    addr_lo   = AW'(lo);
    addr_hi   = AW'(hi);
    start     = 1'b1;
    out_ready = (mode == 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    done_cnt = 0;
    n_acc    = 0;
    if (!exp_err) begin
      model_sum = 16'h0;
      for (int a = lo; a <= hi; a++) exp_q.push_back(8'(a));
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("valid_after_start", 32'(out_valid), 32'd0);
    end
    cycles = 1;
    while (cycles < BUDGET && !done) begin
      if (cycles == 2 && !exp_err) chk("first_valid_latency", 32'(out_valid), 32'd1);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cycles >= hold);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && cycles >= 3 && cycles <= 5) begin
        start   = 1'b1;
        addr_lo = AW'(0);
        addr_hi = AW'(2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    if (exp_cycles >= 0) chk("done_cycle", 32'(cycles), 32'(exp_cycles));
    chk("err", 32'(err), 32'(exp_err));
    chk("checksum_final", 32'(checksum), 32'(exp_sum));
    chk("bytes_accepted", 32'(n_acc), exp_err ? 32'd0 : 32'(hi - lo + 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("idle_not_busy", 32'(busy), 32'd0);
    chk("err_held", 32'(err), 32'(exp_err));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    addr_lo   = '0;
    addr_hi   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst    = 1'b0;
    chk_en = 1'b1;

    // 0..3, ready high: 00..03, checksum 6, done after 2 cycles per byte
    run_scan(0, 3, 0, 0, 16'h0006, 1'b0, 9);
    // Rejected requests leave checksum untouched
    run_scan(10, 9, 0, 0, 16'h0006, 1'b1, 1);
    run_scan(0, 768, 0, 0, 16'h0006, 1'b1, 1);
    // Single address held 10+ cycles; stray start mid-scan must be ignored
    run_scan(5, 5, 1, 12, 16'h0005, 1'b0, 13);
    // Whole ROM: 3*sum(0..255) mod 2^16
    run_scan(0, 767, 0, 0, 16'h7E80, 1'b0, 1537);
    // Random backpressure: sum(100..200) = 15150
    run_scan(100, 200, 2, 0, 16'h3B2E, 1'b0, -1);

    // Reset while a byte at address 50 is presented but not accepted
    addr_lo   = AW'(40);
    addr_hi   = AW'(60);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    model_sum = 16'h0;
    for (int a = 40; a <= 60; a++) exp_q.push_back(8'(a));
    guard = 0;
    while (guard < BUDGET && !(out_valid && rom_addr == AW'(50))) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("reach_addr_50", 32'(out_valid && rom_addr == AW'(50)), 32'd1);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_sum = 16'h0;
    check_reset_values("midscan_reset");
    run_scan(0, 0, 0, 0, 16'h0000, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("quiet_after_scans", 32'(out_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
